// File: rtl/xblock_lsu_pkg.sv
// Shared encodings for the X-block datapath.
//   cu_state_t  : compute-unit state, also used by xblock_rf, PC and scheduler
//   lsu_state_t : load/store unit state as exposed on lsu_state
package xblock_lsu_pkg;

  typedef enum logic [3:0] {
    CU_IDLE      = 4'd0,
    CU_FETCH     = 4'd1,
    CU_DECODE    = 4'd2,
    CU_REQ       = 4'd3,
    CU_WAIT      = 4'd4,
    CU_EXECUTE   = 4'd5,
    CU_WRITEBACK = 4'd6,
    CU_DONE      = 4'd7
  } cu_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'd0,
    LSU_REQUESTING = 2'd1,
    LSU_WAITING    = 2'd2,
    LSU_DONE       = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/xblock_lsu.sv
// Per-X-block load/store unit. Launches one data-memory read (LDR) or write
// (STR) per instruction when the compute unit is in REQ, runs a valid/ready
// handshake with the memory arbiter and holds the loaded value for the
// register file's writeback.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   lsu_enable        X-block active; gates new launches only
//   cu_state          compute-unit state (cu_state_t encoding)
//   is_read/is_write  decoded LDR / STR (read wins if both set)
//   rimm_data         address operand (low ADDR_WIDTH bits used)
//   rs2_data          store data
//   mem_read_*        read request channel (valid/addr out, ready/data in)
//   mem_write_*       write request channel (valid/addr/data out, ready in)
//   lsu_state         current LSU state (lsu_state_t encoding)
//   lsu_load_data     last loaded value
// All outputs are registered.
module xblock_lsu
  import xblock_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lsu_enable,
  input  logic [3:0]            cu_state,
  input  logic                  is_read,
  input  logic                  is_write,
  input  logic [DATA_WIDTH-1:0] rimm_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  mem_read_valid,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic                  mem_read_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_valid,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_write_ready,
  output logic [1:0]            lsu_state,
  output logic [DATA_WIDTH-1:0] lsu_load_data
);

  lsu_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  op_rd_q, op_rd_d;

  logic                  rvalid_d, wvalid_d;
  logic [ADDR_WIDTH-1:0] raddr_d, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_d, load_d;

  // Address operand is wider than the memory address; upper bits are ignored.
  logic unused_rimm_hi;
  assign unused_rimm_hi = ^rimm_data[DATA_WIDTH-1:ADDR_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= LSU_IDLE;
      addr_q          <= '0;
      data_q          <= '0;
      op_rd_q         <= 1'b0;
      mem_read_valid  <= 1'b0;
      mem_read_addr   <= '0;
      mem_write_valid <= 1'b0;
      mem_write_addr  <= '0;
      mem_write_data  <= '0;
      lsu_load_data   <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      op_rd_q         <= op_rd_d;
      mem_read_valid  <= rvalid_d;
      mem_read_addr   <= raddr_d;
      mem_write_valid <= wvalid_d;
      mem_write_addr  <= waddr_d;
      mem_write_data  <= wdata_d;
      lsu_load_data   <= load_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    op_rd_d  = op_rd_q;
    rvalid_d = mem_read_valid;
    raddr_d  = mem_read_addr;
    wvalid_d = mem_write_valid;
    waddr_d  = mem_write_addr;
    wdata_d  = mem_write_data;
    load_d   = lsu_load_data;

    case (state_q)
      LSU_IDLE: begin
        if (lsu_enable && (cu_state == CU_REQ) && (is_read || is_write)) begin
          addr_d  = rimm_data[ADDR_WIDTH-1:0];
          data_d  = rs2_data;
          op_rd_d = is_read;  // read wins when both are decoded
          state_d = LSU_REQUESTING;
        end
      end
      LSU_REQUESTING: begin
        if (op_rd_q) begin
          rvalid_d = 1'b1;
          raddr_d  = addr_q;
        end else begin
          wvalid_d = 1'b1;
          waddr_d  = addr_q;
          wdata_d  = data_q;
        end
        state_d = LSU_WAITING;
      end
      LSU_WAITING: begin
        if (mem_read_valid && mem_read_ready) begin
          load_d   = mem_read_data;
          rvalid_d = 1'b0;
          state_d  = LSU_DONE;
        end else if (mem_write_valid && mem_write_ready) begin
          wvalid_d = 1'b0;
          state_d  = LSU_DONE;
        end
      end
      LSU_DONE: begin
        if (cu_state == CU_WRITEBACK) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  assign lsu_state = state_q;

endmodule

// File: tb/tb_xblock_lsu.sv
// Self-checking bench for xblock_lsu: directed scenarios plus randomized
// transactions, each predicted from a transaction description (op, address,
// data, stall length, done-hold length) rather than a cycle-level copy.
module tb_xblock_lsu;

  localparam int DW = 16;
  localparam int AW = 8;

  localparam logic [3:0] CU_REQ = 4'd3;
  localparam logic [3:0] CU_WAIT = 4'd4;
  localparam logic [3:0] CU_WB  = 4'd6;
  localparam logic [3:0] CU_IDL = 4'd0;

  localparam int S_IDLE = 0;
  localparam int S_REQ  = 1;
  localparam int S_WAIT = 2;
  localparam int S_DONE = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          lsu_enable;
  logic [3:0]    cu_state;
  logic          is_read, is_write;
  logic [DW-1:0] rimm_data, rs2_data;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_addr;
  logic          mem_read_ready;
  logic [DW-1:0] mem_read_data;
  logic          mem_write_valid;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_ready;
  logic [1:0]    lsu_state;
  logic [DW-1:0] lsu_load_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_ld;

  xblock_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .lsu_enable(lsu_enable), .cu_state(cu_state),
    .is_read(is_read), .is_write(is_write), .rimm_data(rimm_data),
    .rs2_data(rs2_data), .mem_read_valid(mem_read_valid),
    .mem_read_addr(mem_read_addr), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .mem_write_valid(mem_write_valid),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_write_ready(mem_write_ready), .lsu_state(lsu_state),
    .lsu_load_data(lsu_load_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 32'(lsu_state), S_IDLE);
    check({tag, "_rv"}, 32'(mem_read_valid), 0);
    check({tag, "_wv"}, 32'(mem_write_valid), 0);
    check({tag, "_ld"}, 32'(lsu_load_data), 32'(exp_ld));
  endtask

  function automatic logic [3:0] rand_cu_not_wb();
    logic [3:0] v;
    v = 4'($urandom_range(0, 6));
    if (v == CU_WB) v = 4'd7;
    return v;
  endfunction

  // One complete LSU transaction. Expected behaviour: launch edge -> REQUESTING;
  // next edge -> WAITING with the request valid; 'stall' cycles without ready;
  // then acceptance -> DONE (reads capture rdata); DONE held for 'hold' non-WB
  // cycles; WRITEBACK returns to IDLE.
  task automatic run_op(input bit rd, input bit wr, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                        input int stall, input int hold, input bit drop_en);
    bit is_rd_op;
    logic [AW-1:0] exp_addr;
    is_rd_op = rd;
    exp_addr = addr[AW-1:0];

    lsu_enable = 1'b1; cu_state = CU_REQ; is_read = rd; is_write = wr;
    rimm_data = addr; rs2_data = wdata;
    mem_read_ready = 1'($urandom); mem_write_ready = 1'($urandom);
    mem_read_data = 16'($urandom);
    step();
    check("launch_state", 32'(lsu_state), S_REQ);
    check("launch_rv", 32'(mem_read_valid), 0);
    check("launch_wv", 32'(mem_write_valid), 0);

    // Operand buses change after launch; the latched values must be used.
    cu_state = CU_WAIT; is_read = 1'($urandom); is_write = 1'($urandom);
    rimm_data = 16'($urandom); rs2_data = 16'($urandom);
    lsu_enable = drop_en ? 1'b0 : 1'b1;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0;
    step();
    for (int i = 0; i <= stall; i++) begin
      check("wait_state", 32'(lsu_state), S_WAIT);
      check("wait_rv", 32'(mem_read_valid), 32'(is_rd_op));
      check("wait_wv", 32'(mem_write_valid), 32'(!is_rd_op));
      if (is_rd_op) check("wait_raddr", 32'(mem_read_addr), 32'(exp_addr));
      else begin
        check("wait_waddr", 32'(mem_write_addr), 32'(exp_addr));
        check("wait_wdata", 32'(mem_write_data), 32'(wdata));
      end
      check("wait_ld", 32'(lsu_load_data), 32'(exp_ld));
      cu_state = 4'($urandom_range(0, 7));
      // Ready on the non-requested channel must be ignored.
      if (is_rd_op) begin
        mem_write_ready = 1'($urandom);
        mem_read_ready  = (i == stall);
      end else begin
        mem_read_ready  = 1'($urandom);
        mem_write_ready = (i == stall);
      end
      mem_read_data = (i == stall) ? rdata : 16'($urandom);
      step();
    end
    if (is_rd_op) exp_ld = rdata;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0;
    lsu_enable = 1'b1;

    for (int i = 0; i <= hold; i++) begin
      check("done_state", 32'(lsu_state), S_DONE);
      check("done_rv", 32'(mem_read_valid), 0);
      check("done_wv", 32'(mem_write_valid), 0);
      check("done_ld", 32'(lsu_load_data), 32'(exp_ld));
      cu_state = (i == hold) ? CU_WB : rand_cu_not_wb();
      is_read = 1'($urandom); is_write = 1'($urandom);
      mem_read_ready = 1'($urandom); mem_read_data = 16'($urandom);
      step();
    end
    check_idle("wb");
    cu_state = CU_IDL; is_read = 1'b0; is_write = 1'b0;
    mem_read_ready = 1'b0; mem_write_ready = 1'b0;
  endtask

  initial begin
    exp_ld = '0;
    reset = 1'b1; lsu_enable = 1'b0; cu_state = CU_IDL;
    is_read = 1'b0; is_write = 1'b0; rimm_data = '0; rs2_data = '0;
    mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
    step(); step();
    check_idle("reset");
    check("reset_raddr", 32'(mem_read_addr), 0);
    check("reset_waddr", 32'(mem_write_addr), 0);
    check("reset_wdata", 32'(mem_write_data), 0);
    reset = 1'b0;
    step();

    // LDR with ready always high: valid for exactly one cycle.
    run_op(1, 0, 16'h0112, 16'h0000, 16'hBEEF, 0, 2, 0);
    check("ldr_value", 32'(lsu_load_data), 32'h0000BEEF);

    // STR with 5 cycles of backpressure; load data untouched.
    run_op(0, 1, 16'h0040, 16'h1234, 16'h5555, 5, 1, 0);

    // Both decoded: read wins.
    run_op(1, 1, 16'h00A7, 16'hCAFE, 16'h7E57, 2, 0, 0);

    // Enable low in REQ: no launch.
    lsu_enable = 1'b0; cu_state = CU_REQ; is_read = 1'b1; rimm_data = 16'h0033;
    step(); step();
    check_idle("noen");
    // Enable high but no op decoded: no launch.
    lsu_enable = 1'b1; is_read = 1'b0; is_write = 1'b0;
    step();
    check_idle("noop");
    cu_state = CU_IDL;

    // Enable dropped during WAITING: still completes.
    run_op(1, 0, 16'h0099, 16'h0000, 16'h0F0F, 3, 0, 1);

    // Stray ready in IDLE: nothing changes.
    mem_read_ready = 1'b1; mem_write_ready = 1'b1; mem_read_data = 16'hDEAD;
    step(); step();
    check_idle("stray");
    mem_read_ready = 1'b0; mem_write_ready = 1'b0;

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      bit rd, wr;
      rd = 1'($urandom); wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      run_op(rd, wr, 16'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
             1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        mem_read_ready = 1'($urandom); mem_write_ready = 1'($urandom);
        step();
        check_idle("rnd_idle");
        mem_read_ready = 1'b0; mem_write_ready = 1'b0;
      end
    end

    // Async reset mid-WAITING, away from the clock edge.
    lsu_enable = 1'b1; cu_state = CU_REQ; is_read = 1'b1; rimm_data = 16'h0021;
    step();
    cu_state = CU_WAIT; is_read = 1'b0;
    step();
    check("pre_rst_state", 32'(lsu_state), S_WAIT);
    check("pre_rst_rv", 32'(mem_read_valid), 1);
    #2 reset = 1'b1;
    #1;
    exp_ld = '0;
    check_idle("async_rst");
    check("async_rst_raddr", 32'(mem_read_addr), 0);
    #1 reset = 1'b0;
    step();
    check_idle("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
